// File: rtl/termbuffer_grid_pkg.sv
// Shared constants, state encodings and sizing helper for the character-grid
// terminal buffer.
package termbuffer_grid_pkg;

    localparam logic [7:0] ASC_ESC  = 8'h1B;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_BS   = 8'h08;
    localparam logic [7:0] ASC_LBRK = 8'h5B;
    localparam logic [7:0] ASC_H    = 8'h48;

    typedef enum logic [1:0] {
        W_INIT,
        W_IDLE,
        W_SCROLL
    } wr_state_t;

    typedef enum logic [1:0] {
        S_HDR,
        S_ROW,
        S_EOL
    } sc_state_t;

    function automatic int addr_w(input int cols, input int rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

endpackage

// File: rtl/termbuffer_grid_if.sv
// Byte-stream ports of the terminal buffer: input stream, output stream with
// backpressure, and the cursor position.
interface termbuffer_grid_if #(
    parameter int COLS = 40,
    parameter int ROWS = 24
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [7:0]    i_serial;
    logic          i_serial_v;
    logic          o_in_rdy;
    logic          o_drop;
    logic [7:0]    o_serial;
    logic          o_serial_v;
    logic          i_serial_rdy;
    logic [CW-1:0] o_cur_col;
    logic [RW-1:0] o_cur_row;

    modport slave (
        input  i_serial, i_serial_v, i_serial_rdy,
        output o_in_rdy, o_drop, o_serial, o_serial_v, o_cur_col, o_cur_row
    );

    modport master (
        output i_serial, i_serial_v, i_serial_rdy,
        input  o_in_rdy, o_drop, o_serial, o_serial_v, o_cur_col, o_cur_row
    );

endinterface

// File: rtl/termbuffer_grid_ram.sv
// Simple dual-port screen memory: port A writes, port B registered read that
// holds its data while the read enable is low.
module termbuffer_grid_ram #(
    parameter int DEPTH = 960,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-cycle write to the read cell returns the old byte.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/termbuffer_grid.sv
// Character-grid terminal: writer FSM maintains the screen, cursor and hardware
// scroll; scanner FSM replays the whole screen as a serial stream.
module termbuffer_grid
    import termbuffer_grid_pkg::*;
#(
    parameter int         COLS = 40,
    parameter int         ROWS = 24,
    parameter logic [7:0] FILL = 8'h20
) (
    input logic              clk,
    input logic              rst,
    termbuffer_grid_if.slave bus
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = addr_w(COLS, ROWS);
    localparam int N  = COLS * ROWS;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [AW-1:0] CELL_LAST = AW'(N - 1);

    // Logical row is rotated by the scroll offset to find the physical row.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] lrow,
                                                input logic [RW-1:0] top_row,
                                                input logic [CW-1:0] col);
        logic [RW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top_row};
        if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
        return AW'(sum) * AW'(COLS) + AW'(col);
    endfunction

    // ---------------- writer ----------------
    wr_state_t     wst, wst_nx;
    logic [AW-1:0] init_cnt, init_cnt_nx;
    logic [CW-1:0] cur_col, col_nx, clr_col, clr_col_nx;
    logic [RW-1:0] cur_row, row_nx, top, top_nx;
    logic          in_rdy, drop_q, do_lf;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    assign in_rdy = (wst == W_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst      <= W_INIT;
            init_cnt <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            top      <= '0;
            clr_col  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wst      <= wst_nx;
            init_cnt <= init_cnt_nx;
            cur_col  <= col_nx;
            cur_row  <= row_nx;
            top      <= top_nx;
            clr_col  <= clr_col_nx;
            drop_q   <= bus.i_serial_v & ~in_rdy;
        end
    end

    always_comb begin
        wst_nx      = wst;
        init_cnt_nx = init_cnt;
        col_nx      = cur_col;
        row_nx      = cur_row;
        top_nx      = top;
        clr_col_nx  = clr_col;
        we          = 1'b0;
        waddr       = init_cnt;
        wdata       = FILL;
        do_lf       = 1'b0;
        case (wst)
            W_INIT: begin
                we = 1'b1;
                if (init_cnt == CELL_LAST) wst_nx = W_IDLE;
                else init_cnt_nx = init_cnt + 1'b1;
            end
            W_IDLE: begin
                if (bus.i_serial_v) begin
                    if (bus.i_serial >= 8'h20 && bus.i_serial <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cell_addr(cur_row, top, cur_col);
                        wdata = bus.i_serial;
                        if (cur_col == COL_LAST) begin
                            col_nx = '0;
                            do_lf  = 1'b1;
                        end else begin
                            col_nx = cur_col + 1'b1;
                        end
                    end else if (bus.i_serial == ASC_CR) begin
                        col_nx = '0;
                    end else if (bus.i_serial == ASC_BS) begin
                        if (cur_col != '0) col_nx = cur_col - 1'b1;
                    end else if (bus.i_serial == ASC_LF) begin
                        do_lf = 1'b1;
                    end
                    if (do_lf) begin
                        if (cur_row != ROW_LAST) begin
                            row_nx = cur_row + 1'b1;
                        end else begin
                            wst_nx     = W_SCROLL;
                            top_nx     = (top == ROW_LAST) ? '0 : top + 1'b1;
                            clr_col_nx = '0;
                        end
                    end
                end
            end
            W_SCROLL: begin
                // Offset already advanced, so logical last row is the freed row.
                we    = 1'b1;
                waddr = cell_addr(ROW_LAST, top, clr_col);
                if (clr_col == COL_LAST) wst_nx = W_IDLE;
                else clr_col_nx = clr_col + 1'b1;
            end
            default: wst_nx = W_INIT;
        endcase
    end

    // ---------------- scanner ----------------
    sc_state_t     sst, sst_nx;
    logic [RW-1:0] srow, srow_nx;
    logic [CW-1:0] scol, scol_nx;
    logic [1:0]    sidx, sidx_nx;
    logic          s1_v, s1_ram, out_v, out_free, issue, iss_ram, re;
    logic [7:0]    s1_byte, out_b, iss_byte, rdata;
    logic [AW-1:0] raddr;

    // Stage 1 holds the byte whose RAM read is in flight; out_b is the output reg.
    assign out_free = ~out_v | bus.i_serial_rdy;
    assign issue    = ~s1_v | out_free;
    assign re       = issue & iss_ram;

    always_comb begin
        sst_nx   = sst;
        srow_nx  = srow;
        scol_nx  = scol;
        sidx_nx  = sidx;
        iss_ram  = 1'b0;
        iss_byte = 8'h00;
        raddr    = cell_addr(srow, top, scol);
        case (sst)
            S_HDR: begin
                iss_byte = (sidx == 2'd0) ? ASC_ESC : (sidx == 2'd1) ? ASC_LBRK : ASC_H;
                if (issue) begin
                    if (sidx == 2'd2) begin
                        sidx_nx = '0;
                        scol_nx = '0;
                        sst_nx  = S_ROW;
                    end else begin
                        sidx_nx = sidx + 1'b1;
                    end
                end
            end
            S_ROW: begin
                iss_ram = 1'b1;
                if (issue) begin
                    if (scol == COL_LAST) begin
                        scol_nx = '0;
                        sidx_nx = '0;
                        sst_nx  = S_EOL;
                    end else begin
                        scol_nx = scol + 1'b1;
                    end
                end
            end
            S_EOL: begin
                iss_byte = (sidx == 2'd0) ? ASC_CR : ASC_LF;
                if (issue) begin
                    if (sidx == 2'd1) begin
                        sidx_nx = '0;
                        if (srow == ROW_LAST) begin
                            srow_nx = '0;
                            sst_nx  = S_HDR;
                        end else begin
                            srow_nx = srow + 1'b1;
                            sst_nx  = S_ROW;
                        end
                    end else begin
                        sidx_nx = sidx + 1'b1;
                    end
                end
            end
            default: sst_nx = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sst     <= S_HDR;
            srow    <= '0;
            scol    <= '0;
            sidx    <= '0;
            s1_v    <= 1'b0;
            s1_ram  <= 1'b0;
            s1_byte <= 8'h00;
            out_v   <= 1'b0;
            out_b   <= 8'h00;
        end else begin
            sst  <= sst_nx;
            srow <= srow_nx;
            scol <= scol_nx;
            sidx <= sidx_nx;
            if (issue) begin
                s1_v    <= 1'b1;
                s1_ram  <= iss_ram;
                s1_byte <= iss_byte;
            end
            if (out_free) begin
                out_v <= s1_v;
                if (s1_v) out_b <= s1_ram ? rdata : s1_byte;
            end
        end
    end

    termbuffer_grid_ram #(.DEPTH(N), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.o_in_rdy   = in_rdy;
    assign bus.o_drop     = drop_q;
    assign bus.o_serial   = out_b;
    assign bus.o_serial_v = out_v;
    assign bus.o_cur_col  = cur_col;
    assign bus.o_cur_row  = cur_row;

endmodule

// File: tb/tb_termbuffer_grid.sv
// Self-checking bench: directed and random byte streams against a row-array
// screen model; captured output frames are compared byte by byte.
module tb_termbuffer_grid;
    import termbuffer_grid_pkg::*;

    localparam int         COLS  = 8;
    localparam int         ROWS  = 4;
    localparam int         FRAME = 3 + ROWS * (COLS + 2);
    localparam logic [7:0] FILL  = 8'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    termbuffer_grid_if #(.COLS(COLS), .ROWS(ROWS)) bus();

    termbuffer_grid #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Screen model: logical rows, scrolling physically shifts rows up.
    logic [7:0] scr [ROWS][COLS];
    int mcol, mrow;

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = FILL;
        mcol = 0;
        mrow = 0;
    endfunction

    function automatic void m_lf();
        if (mrow < ROWS - 1) mrow++;
        else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = FILL;
        end
    endfunction

    function automatic void m_put(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            if (mcol == COLS - 1) begin
                mcol = 0;
                m_lf();
            end else mcol++;
        end else if (b == 8'h0D) mcol = 0;
        else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0A) m_lf();
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        int j, r, c;
        if (i == 0) return 8'h1B;
        if (i == 1) return 8'h5B;
        if (i == 2) return 8'h48;
        j = i - 3;
        r = j / (COLS + 2);
        c = j % (COLS + 2);
        if (c < COLS) return scr[r][c];
        return (c == COLS) ? 8'h0D : 8'h0A;
    endfunction

    // Output monitor: collect accepted bytes, check stability under stall.
    logic [7:0] rxq[$];
    int         rdy_mode = 0;
    logic       stall_p = 1'b0;
    logic [7:0] byte_p = 8'h00;

    always @(negedge clk) begin
        if (rst) stall_p = 1'b0;
        else begin
            if (stall_p) begin
                chk("hold_valid", bus.o_serial_v, 1);
                chk("hold_byte", bus.o_serial, byte_p);
            end
            if (bus.o_serial_v && bus.i_serial_rdy) rxq.push_back(bus.o_serial);
            stall_p = bus.o_serial_v && !bus.i_serial_rdy;
            byte_p  = bus.o_serial;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.i_serial_rdy = 1'b1;
                1:       bus.i_serial_rdy = ~bus.i_serial_rdy;
                default: bus.i_serial_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!bus.o_in_rdy && n < 200) begin
            tick();
            n++;
        end
        chk("in_rdy_wait", bus.o_in_rdy, 1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_rdy();
        bus.i_serial   = b;
        bus.i_serial_v = 1'b1;
        tick();
        bus.i_serial_v = 1'b0;
        m_put(b);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.i_serial_v = 1'b0;
        tick();
        tick();
        rxq.delete();
        m_clear();
        rst = 1'b0;
        wait_rdy();
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(bus.o_cur_col), mcol);
        chk({tag, "_row"}, 32'(bus.o_cur_row), mrow);
    endtask

    task automatic chk_frame(input string tag);
        int n = 0;
        while (n < 2000) begin
            while (rxq.size() > 0 && rxq[0] != 8'h1B) void'(rxq.pop_front());
            if (rxq.size() >= FRAME) break;
            tick();
            n++;
        end
        chk({tag, "_timeout"}, rxq.size() >= FRAME, 1);
        if (rxq.size() >= FRAME)
            for (int i = 0; i < FRAME; i++) chk(tag, rxq.pop_front(), exp_byte(i));
    endtask

    task automatic next_frame(input string tag);
        wait_rdy();
        rxq.delete();
        chk_frame(tag);
    endtask

    initial begin
        logic [7:0] b;
        int low, n;
        bus.i_serial     = 8'h00;
        bus.i_serial_v   = 1'b0;
        bus.i_serial_rdy = 1'b1;
        m_clear();
        tick();
        tick();
        chk("rst_out_v", bus.o_serial_v, 0);
        chk("rst_out", bus.o_serial, 0);
        chk("rst_in_rdy", bus.o_in_rdy, 0);
        chk("rst_drop", bus.o_drop, 0);
        chk_cursor("rst");

        // Release: ESC latency and INIT length.
        rxq.delete();
        rst = 1'b0;
        for (int k = 1; k <= COLS * ROWS; k++) begin
            tick();
            if (k == 1) chk("esc_lat1", bus.o_serial_v, 0);
            if (k == 2) begin
                chk("esc_lat2_v", bus.o_serial_v, 1);
                chk("esc_lat2_b", bus.o_serial, 8'h1B);
            end
            if (k == COLS * ROWS - 1) chk("init_busy", bus.o_in_rdy, 0);
            if (k == COLS * ROWS) chk("init_done", bus.o_in_rdy, 1);
        end
        chk_frame("frame_blank");

        // Overwrite after carriage return.
        do_reset();
        send("A"); send("B"); send(8'h0D); send("C");
        chk_cursor("cr");
        next_frame("frame_cr");

        // Line wrap.
        do_reset();
        repeat (9) send("x");
        chk_cursor("wrap");
        next_frame("frame_wrap");

        // Scroll, with a byte lost during the clear.
        do_reset();
        send("a"); send(8'h0A); send("b"); send(8'h0A);
        send("c"); send(8'h0A); send("d"); send(8'h0A);
        chk("scroll_rdy0", bus.o_in_rdy, 0);
        bus.i_serial   = "e";
        bus.i_serial_v = 1'b1;
        tick();
        bus.i_serial_v = 1'b0;
        chk("drop_pulse", bus.o_drop, 1);
        low = 1;
        while (!bus.o_in_rdy && low < 50) begin
            tick();
            low++;
        end
        chk("scroll_len", low, COLS);
        chk("drop_clear", bus.o_drop, 0);
        chk_cursor("scroll");
        next_frame("frame_scroll");

        // Backpressure toggling every cycle.
        rdy_mode = 1;
        next_frame("frame_bp");
        rdy_mode = 0;

        // Random bytes with random backpressure.
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: b = 8'($urandom_range(8'h20, 8'h7E));
                6:       b = 8'h0D;
                7:       b = 8'h0A;
                8:       b = 8'h08;
                default: b = 8'($urandom);
            endcase
            send(b);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_rdy();
        chk_cursor("rand");
        next_frame("frame_rand");
        rdy_mode = 0;

        // Reset in the middle of a frame.
        rxq.delete();
        n = 0;
        while (rxq.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        chk("midframe_reach", rxq.size() >= 10, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_v", bus.o_serial_v, 0);
        chk("midrst_in_rdy", bus.o_in_rdy, 0);
        tick();
        rxq.delete();
        m_clear();
        rst = 1'b0;
        chk_frame("frame_after_rst");
        chk_cursor("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
